// File: rtl/reg_wr_pkg.sv
// Shared types and helpers for the register-file write decoder.
package reg_wr_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned MAX_WR     = 4;

    // Default-width one-hot register vector (NREGS = 2**ADDR_W_DEF).
    typedef logic [(1 << ADDR_W_DEF)-1:0] onehot_t;

    // Number of registers addressed by an addr_w-bit index.
    function automatic int unsigned nregs(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Priority resolve for one register: 1 when any lower-indexed port also targets it.
    function automatic logic lower_hit(input logic [MAX_WR-1:0] hits, input int unsigned port);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_WR; i++) begin
            if (i < port) begin
                hit = hit | hits[i];
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable.
module onehot_dec #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        adr,
    output logic [(1 << ADDR_W)-1:0] onehot_c
);

    // Single bit set at adr when enabled.
    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[adr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_wr_decoder.sv
// Registered register-file write decoder with collision priority and counter.
// Optional busy scoreboard enabled by defining REG_WR_DECODER_SCOREBOARD_EN.
module reg_wr_decoder
    import reg_wr_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned NUM_WR      = 2,
    parameter bit          HARDWIRE_R0 = 1'b1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]       wr_adr,
    output logic [NUM_WR*(1<<ADDR_W)-1:0]  wr_onehot,
    output logic [(1<<ADDR_W)-1:0]         wr_mask,
    output logic [NUM_WR-1:0]              wr_valid,
    output logic                           collision,
    output logic [CNT_W-1:0]               coll_cnt
`ifdef REG_WR_DECODER_SCOREBOARD_EN
    ,
    input  logic                           iss_en,
    input  logic [ADDR_W-1:0]              iss_adr,
    output logic [(1<<ADDR_W)-1:0]         busy
`endif
);

    localparam int unsigned NREGS = nregs(ADDR_W);

    logic [NUM_WR-1:0][NREGS-1:0] raw_c;
    logic [NUM_WR-1:0][NREGS-1:0] win_c;
    logic [NUM_WR-1:0]            en_c;
    logic [NUM_WR-1:0]            valid_c;
    logic [NREGS-1:0]             mask_c;
    logic [MAX_WR-1:0]            hits_c;
    logic                         lower_c;
    logic                         coll_c;

    // Per-port decode; writes to a hardwired register 0 never enter resolution.
    for (genvar p = 0; p < NUM_WR; p++) begin : g_port
        logic [ADDR_W-1:0] adr;
        assign adr     = wr_adr[p*ADDR_W +: ADDR_W];
        assign en_c[p] = wr_en[p] && !(HARDWIRE_R0 && (adr == '0));
        onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
            .en       (en_c[p]),
            .adr      (adr),
            .onehot_c (raw_c[p])
        );
    end

    // Lowest port wins each register; any shadowed hit flags a collision.
    always_comb begin
        win_c   = '0;
        valid_c = '0;
        mask_c  = '0;
        hits_c  = '0;
        lower_c = 1'b0;
        coll_c  = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            hits_c = '0;
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                hits_c[p] = raw_c[p][r];
            end
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                lower_c     = lower_hit(hits_c, p);
                win_c[p][r] = raw_c[p][r] & ~lower_c;
                coll_c      = coll_c | (raw_c[p][r] & lower_c);
            end
        end
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            valid_c[p] = |win_c[p];
            mask_c     = mask_c | win_c[p];
        end
    end

    // Output stage and saturating collision counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_onehot <= '0;
            wr_mask   <= '0;
            wr_valid  <= '0;
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            wr_onehot <= win_c;
            wr_mask   <= mask_c;
            wr_valid  <= valid_c;
            collision <= coll_c;
            if (coll_c && (coll_cnt != {CNT_W{1'b1}})) begin
                coll_cnt <= coll_cnt + CNT_W'(1);
            end
        end
    end

`ifdef REG_WR_DECODER_SCOREBOARD_EN
    logic             iss_en_c;
    logic [NREGS-1:0] iss_oh_c;

    assign iss_en_c = iss_en && !(HARDWIRE_R0 && (iss_adr == '0));

    onehot_dec #(.ADDR_W(ADDR_W)) u_iss_dec (
        .en       (iss_en_c),
        .adr      (iss_adr),
        .onehot_c (iss_oh_c)
    );

    // Busy set on issue, cleared as the write leaves; issue wins a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_mask) | iss_oh_c;
        end
    end
`endif

endmodule
